// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : One requester port of the data-memory arbiter
//            (request/grant handshake plus read return).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    // Requester side (CPU load/store path, loader, DMA)
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin, burst-capped arbiter sharing one synchronous data
//            memory / I/O space between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    dmem_arbiter_if.slave       port_a,
    dmem_arbiter_if.slave       port_b,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    output logic                mem_we,
    input  wire logic [DW-1:0]  mem_dout
);

    localparam logic [3:0] c_burst_cap = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_b;
    logic [3:0] r_burst_cnt;
    logic       r_rvalid_a;
    logic       r_rvalid_b;

    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_at_cap;

    assign w_gnt_a  = (r_state == ST_OWN_A) && port_a.req;
    assign w_gnt_b  = (r_state == ST_OWN_B) && port_b.req;
    assign w_at_cap = (r_burst_cnt == c_burst_cap);

    // Next-state: an owner keeps the port until it drops its request or the
    // other side is waiting when the burst cap is reached.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (port_a.req && port_b.req)
                    w_state_nxt = r_last_b ? ST_OWN_A : ST_OWN_B;
                else if (port_a.req)
                    w_state_nxt = ST_OWN_A;
                else if (port_b.req)
                    w_state_nxt = ST_OWN_B;
            end
            ST_OWN_A: begin
                if (!port_a.req)
                    w_state_nxt = port_b.req ? ST_OWN_B : ST_IDLE;
                else if (w_at_cap && port_b.req)
                    w_state_nxt = ST_OWN_B;
            end
            ST_OWN_B: begin
                if (!port_b.req)
                    w_state_nxt = port_a.req ? ST_OWN_A : ST_IDLE;
                else if (w_at_cap && port_a.req)
                    w_state_nxt = ST_OWN_A;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_last_b    <= 1'b1;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_OWN_A && w_state_nxt != ST_OWN_A)
                r_last_b <= 1'b0;
            else if (r_state == ST_OWN_B && w_state_nxt != ST_OWN_B)
                r_last_b <= 1'b1;

            // Saturate at the cap so a lone owner keeps streaming indefinitely.
            if (w_state_nxt != r_state)
                r_burst_cnt <= 4'd0;
            else if ((w_gnt_a || w_gnt_b) && !w_at_cap)
                r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    // Read return is tagged with the port that issued it, so a handover
    // between issue and return does not misroute the strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= w_gnt_a && !port_a.we;
            r_rvalid_b <= w_gnt_b && !port_b.we;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (w_gnt_a) begin
            mem_addr = port_a.addr;
            mem_din  = port_a.wdata;
            mem_we   = port_a.we;
        end else if (w_gnt_b) begin
            mem_addr = port_b.addr;
            mem_din  = port_b.wdata;
            mem_we   = port_b.we;
        end
    end

    assign port_a.gnt    = w_gnt_a;
    assign port_b.gnt    = w_gnt_b;
    assign port_a.rvalid = r_rvalid_a;
    assign port_b.rvalid = r_rvalid_b;
    assign port_a.rdata  = mem_dout;
    assign port_b.rdata  = mem_dout;

endmodule
`default_nettype wire
